// File: rtl/cordic_pkg.sv
// Shared constants and helpers for the CORDIC datapath stages.
// Gain constant, coefficient quantiser and symmetric clipping.
package cordic_pkg;

    localparam real K_INV = 0.6072529350088813;

    // round(2^(bits-1) * K_INV), i.e. 1/K in Q1.(bits-1)
    function automatic int k_inv_q(input int bits);
        real scale;
        scale = 1.0;
        for (int i = 1; i < bits; i++) scale = scale * 2.0;
        return int'(scale * K_INV);
    endfunction

    // Clip a signed value into the range of a width-bit two's complement word.
    function automatic logic signed [63:0] sat_trunc(input logic signed [63:0] value,
                                                     input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (value > hi) return hi;
        else if (value < lo) return lo;
        else return value;
    endfunction

endpackage

// File: rtl/cordic_gain_lane.sv
// One coordinate of the gain compensator: multiply by 1/K (stage 1),
// round half up and saturate (stage 2). Each stage loads on its enable.
module cordic_gain_lane
    import cordic_pkg::*;
#(
    parameter int width      = 16,
    parameter int coef_bits  = 18,
    parameter int k_inv_coef = 79594
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    en1,
    input  logic                    en2,
    input  logic signed [width:0]   d_in,
    output logic signed [width-1:0] d_out,
    output logic                    clip
);

    localparam int PW = width + coef_bits + 1;
    localparam logic signed [PW-1:0] COEF = PW'(k_inv_coef);
    localparam logic signed [PW-1:0] HALF = PW'(2 ** (coef_bits - 2));

    logic signed [PW-1:0]    prod_d, prod_q;
    logic signed [PW-1:0]    rnd;
    logic signed [63:0]      r_wide, clipped;
    logic signed [width-1:0] res_d, res_q;
    logic                    clip_d, clip_q;

    always_comb begin
        prod_d  = en1 ? PW'(d_in) * COEF : prod_q;
        rnd     = (prod_q + HALF) >>> (coef_bits - 1);
        r_wide  = 64'(rnd);
        clipped = sat_trunc(r_wide, width);
        res_d   = en2 ? clipped[width-1:0] : res_q;
        clip_d  = en2 ? (clipped != r_wide) : clip_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prod_q <= '0;
            res_q  <= '0;
            clip_q <= 1'b0;
        end else begin
            prod_q <= prod_d;
            res_q  <= res_d;
            clip_q <= clip_d;
        end
    end

    assign d_out = res_q;
    assign clip  = clip_q;

endmodule

// File: rtl/cordic_gain_comp.sv
// Removes the CORDIC gain K from x/y with a two-stage, fully backpressured
// pipeline; z rides alongside and a saturating counter tracks clipped outputs.
module cordic_gain_comp
    import cordic_pkg::*;
#(
    parameter int width      = 16,
    parameter int coef_bits  = 18,
    parameter int k_inv_coef = 79594,
    parameter int cnt_bits   = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic signed [width:0]      x_in,
    input  logic signed [width:0]      y_in,
    input  logic signed [width-1:0]    z_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic signed [width-1:0]    x_out,
    output logic signed [width-1:0]    y_out,
    output logic signed [width-1:0]    z_out,
    output logic                       sat,
    output logic        [cnt_bits-1:0] sat_count,
    input  logic                       clear_count
);

    logic                    en1, en2;
    logic                    s1_valid_d, s1_valid_q;
    logic                    s2_valid_d, s2_valid_q;
    logic signed [width-1:0] z1_d, z1_q, z2_d, z2_q;
    logic [cnt_bits-1:0]     sat_count_d, sat_count_q;
    logic                    x_clip, y_clip;

    // A stage may load when it is empty or its contents move on this cycle.
    always_comb begin
        en2        = !s2_valid_q || out_ready;
        en1        = !s1_valid_q || en2;
        s1_valid_d = en1 ? in_valid : s1_valid_q;
        s2_valid_d = en2 ? s1_valid_q : s2_valid_q;
        z1_d       = en1 ? z_in : z1_q;
        z2_d       = en2 ? z1_q : z2_q;
    end

    // Clear wins over increment; the count sticks at all-ones.
    always_comb begin
        sat_count_d = sat_count_q;
        if (clear_count)
            sat_count_d = '0;
        else if (s2_valid_q && out_ready && sat && !(&sat_count_q))
            sat_count_d = sat_count_q + cnt_bits'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            z1_q        <= '0;
            z2_q        <= '0;
            sat_count_q <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            z1_q        <= z1_d;
            z2_q        <= z2_d;
            sat_count_q <= sat_count_d;
        end
    end

    cordic_gain_lane #(.width(width), .coef_bits(coef_bits), .k_inv_coef(k_inv_coef)) u_lane_x (
        .clk(clk), .reset(reset), .en1(en1), .en2(en2),
        .d_in(x_in), .d_out(x_out), .clip(x_clip)
    );

    cordic_gain_lane #(.width(width), .coef_bits(coef_bits), .k_inv_coef(k_inv_coef)) u_lane_y (
        .clk(clk), .reset(reset), .en1(en1), .en2(en2),
        .d_in(y_in), .d_out(y_out), .clip(y_clip)
    );

    assign in_ready  = en1;
    assign out_valid = s2_valid_q;
    assign z_out     = z2_q;
    assign sat       = x_clip || y_clip;
    assign sat_count = sat_count_q;

endmodule

// File: tb/tb_cordic_gain_comp.sv
// Bench for cordic_gain_comp: fixed vectors, randomized backpressure stream,
// angle sweep, mid-stream reset and counter saturation/clear corners.
module tb_cordic_gain_comp;

    logic clk = 1'b0;
    logic reset, in_valid, out_ready, clear_count, in_ready, out_valid, sat;
    logic signed [16:0] x_in, y_in;
    logic signed [15:0] z_in, x_out, y_out, z_out;
    logic [15:0] sat_count;

    always #5 clk = ~clk;

    cordic_gain_comp dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .x_in(x_in), .y_in(y_in), .z_in(z_in), .out_valid(out_valid),
        .out_ready(out_ready), .x_out(x_out), .y_out(y_out), .z_out(z_out),
        .sat(sat), .sat_count(sat_count), .clear_count(clear_count)
    );

    typedef struct {
        int x, y, z;
        int ex, ey;
        bit es;
        bit tol;
        int ix, iy;
    } smp_t;

    typedef struct {
        int x, y;
        int ex, ey;
        bit es;
    } vec_t;

    smp_t q[$];
    smp_t nil;
    int checks = 0;
    int errors = 0;
    int mcnt = 0;
    int xfers = 0;
    bit last_acc = 0;
    bit prev_stall = 0;
    logic signed [15:0] px, py, pz;
    logic ps;

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, act, exp);
        end
    endtask

    // Ideal 1/K scaling with round half up and clipping to 16 bits.
    function automatic int comp(input int v, output bit c);
        real r;
        r = $floor(real'(v) * 79594.0 / 131072.0 + 0.5);
        c = 1'b0;
        if (r > 32767.0) begin c = 1'b1; return 32767; end
        if (r < -32768.0) begin c = 1'b1; return -32768; end
        return int'(r);
    endfunction

    function automatic smp_t mk(input int x, input int y, input int z);
        smp_t s;
        bit cx, cy;
        s.x = x; s.y = y; s.z = z;
        s.ex = comp(x, cx);
        s.ey = comp(y, cy);
        s.es = cx | cy;
        s.tol = 1'b0; s.ix = 0; s.iy = 0;
        return s;
    endfunction

    function automatic int iabs(input int v);
        return (v < 0) ? -v : v;
    endfunction

    // One clock cycle: drive at negedge, check all outputs against the model.
    task automatic cyc(input bit iv, input smp_t s, input bit ordy, input bit clr);
        smp_t e;
        bit xfer;
        @(negedge clk);
        in_valid = iv; x_in = 17'(s.x); y_in = 17'(s.y); z_in = 16'(s.z);
        out_ready = ordy; clear_count = clr;
        #1;
        chk("in_ready", in_ready, (q.size() == 2 && !ordy) ? 0 : 1);
        chk("sat_count", sat_count, mcnt);
        if (prev_stall) begin
            chk("stall_valid", out_valid, 1);
            chk("stall_x", x_out, px);
            chk("stall_y", y_out, py);
            chk("stall_z", z_out, pz);
            chk("stall_sat", sat, ps);
        end
        if (out_valid) begin
            if (q.size() == 0) chk("spurious_out", out_valid, 0);
            else begin
                e = q[0];
                chk("x_out", x_out, e.ex);
                chk("y_out", y_out, e.ey);
                chk("z_out", z_out, e.z);
                chk("sat", sat, e.es);
                if (e.tol) begin
                    chk("cos_err_le2", iabs(int'(x_out) - e.ix) <= 2, 1);
                    chk("sin_err_le2", iabs(int'(y_out) - e.iy) <= 2, 1);
                    chk("sweep_sat0", sat, 0);
                end
            end
        end
        last_acc = iv && in_ready;
        xfer = out_valid && ordy && q.size() > 0;
        prev_stall = out_valid && !ordy;
        px = x_out; py = y_out; pz = z_out; ps = sat;
        if (clr) mcnt = 0;
        else if (xfer && q[0].es && mcnt < 65535) mcnt++;
        if (xfer) begin
            void'(q.pop_front());
            xfers++;
        end
        if (last_acc) q.push_back(s);
    endtask

    initial begin
        vec_t tbl[7];
        smp_t cur, satsmp;
        int i, budget;

        tbl[0] = '{53959, -53959, 32767, -32767, 1'b0};
        tbl[1] = '{100, -100, 61, -61, 1'b0};
        tbl[2] = '{1, -1, 1, -1, 1'b0};
        tbl[3] = '{-1, 1, -1, 1, 1'b0};
        tbl[4] = '{0, 0, 0, 0, 1'b0};
        tbl[5] = '{54000, -54000, 32767, -32768, 1'b1};
        tbl[6] = '{-65536, 0, -32768, 0, 1'b1};

        nil = mk(0, 0, 0);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1; clear_count = 1'b0;
        x_in = '0; y_in = '0; z_in = '0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_x_out", x_out, 0);
        chk("rst_y_out", y_out, 0);
        chk("rst_z_out", z_out, 0);
        chk("rst_sat", sat, 0);
        chk("rst_sat_count", sat_count, 0);
        reset = 1'b0;
        @(negedge clk); #1;
        chk("rst_in_ready", in_ready, 1);

        // fixed vectors with latency check
        for (int k = 0; k < 7; k++) begin
            cyc(1'b1, mk(tbl[k].x, tbl[k].y, 5), 1'b1, 1'b0);
            cyc(1'b0, nil, 1'b1, 1'b0);
            chk("lat1_valid", out_valid, 0);
            cyc(1'b0, nil, 1'b1, 1'b0);
            chk("lat2_valid", out_valid, 1);
            chk("tbl_x", x_out, tbl[k].ex);
            chk("tbl_y", y_out, tbl[k].ey);
            chk("tbl_z", z_out, 5);
            chk("tbl_sat", sat, tbl[k].es);
        end
        cyc(1'b0, nil, 1'b1, 1'b0);
        chk("sat_count_2", sat_count, 2);

        // randomized backpressure stream
        i = 0; budget = 0; xfers = 0;
        cur = mk(-64000, int'($urandom_range(0, 131071)) - 65536, 0);
        while ((i < 100 || q.size() > 0) && budget < 3000) begin
            cyc((i < 100) && ($urandom_range(0, 9) != 0), cur, $urandom_range(0, 99) >= 30, 1'b0);
            if (last_acc) begin
                i++;
                cur = mk(i * 1300 - 64000, int'($urandom_range(0, 131071)) - 65536, i);
            end
            budget++;
        end
        chk("stream_in_count", i, 100);
        chk("stream_out_count", xfers, 100);
        chk("stream_drained", q.size(), 0);

        // reset with both stages full
        cyc(1'b1, mk(100, -100, 7), 1'b0, 1'b0);
        cyc(1'b1, mk(200, 0, 8), 1'b0, 1'b0);
        cyc(1'b0, nil, 1'b0, 1'b0);
        chk("full_in_ready", in_ready, 0);
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_sat_count", sat_count, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        q.delete(); mcnt = 0; prev_stall = 1'b0;
        repeat (6) cyc(1'b0, nil, 1'b1, 1'b0);

        // angle sweep through CORDIC-scaled inputs
        for (int k = 0; k < 4096; k++) begin
            logic signed [15:0] zz;
            real th;
            smp_t s;
            zz = 16'(k * 16);
            th = real'(zz) * 3.141592653589793 / 32768.0;
            s = mk(int'($floor(1.6467602581210656 * 32767.0 * $cos(th) + 0.5)),
                   int'($floor(1.6467602581210656 * 32767.0 * $sin(th) + 0.5)), int'(zz));
            s.tol = 1'b1;
            s.ix = int'($floor(32767.0 * $cos(th) + 0.5));
            s.iy = int'($floor(32767.0 * $sin(th) + 0.5));
            cyc(1'b1, s, 1'b1, 1'b0);
        end
        repeat (3) cyc(1'b0, nil, 1'b1, 1'b0);
        chk("sweep_drained", q.size(), 0);

        // counter fill, stick and coincident clear
        satsmp = mk(54000, 0, 3);
        for (int n = 0; n < 65535; n++) cyc(1'b1, satsmp, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, nil, 1'b1, 1'b0);
        chk("cnt_full", sat_count, 65535);
        cyc(1'b1, satsmp, 1'b1, 1'b0);
        repeat (3) cyc(1'b0, nil, 1'b1, 1'b0);
        chk("cnt_stick", sat_count, 65535);
        cyc(1'b1, satsmp, 1'b1, 1'b0);
        cyc(1'b0, nil, 1'b1, 1'b0);
        cyc(1'b0, nil, 1'b1, 1'b1);
        cyc(1'b0, nil, 1'b1, 1'b0);
        chk("clr_vs_inc", sat_count, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
